// File: rtl/pc_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : pc_sequencer
// Brief    : Next-PC controller for the PC register. Selects increment,
//            branch/jump redirect, hazard stall or multdiv hold, and drives a
//            timed flush after every redirect.
//            Optional exception vectoring: PC_SEQ_EXC_VECTOR_EN
// Revision : 1.0 - initial release
//==============================================================================
module pc_sequencer #(
    parameter int PC_W         = 12,
    parameter int FLUSH_CYCLES = 2
`ifdef PC_SEQ_EXC_VECTOR_EN
    ,
    parameter logic [PC_W-1:0] EXC_VEC = 12'hFF0
`endif
) (
    input  logic            clock_i,
    input  logic            ctrl_reset_i,
    input  logic [PC_W-1:0] pc_cur_i,
    input  logic            stall_in_i,
    input  logic            md_start_i,
    input  logic            md_ready_i,
    input  logic            br_taken_i,
    input  logic [PC_W-1:0] br_target_i,
    input  logic            jump_valid_i,
    input  logic [PC_W-1:0] jump_target_i,
`ifdef PC_SEQ_EXC_VECTOR_EN
    input  logic            exc_req_i,
    output logic [PC_W-1:0] epc_o,
`endif
    output logic [PC_W-1:0] pc_next_o,
    output logic            pc_we_o,
    output logic            flush_o,
    output logic            md_busy_o,
    output logic [1:0]      seq_state_o
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MD_WAIT = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_UNUSED  = 2'd3
    } state_e;

    localparam logic [PC_W-1:0] PC_ONE     = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [2:0]      FLUSH_LOAD = 3'(FLUSH_CYCLES);

    state_e          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            flush_q;
    logic            busy_q;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_next_d;
    logic            pc_we_d;
    logic            redirect;
    logic [PC_W-1:0] redirect_tgt;

    assign pc_inc = pc_cur_i + PC_ONE;

    // Jump outranks branch; both behave identically apart from the target.
    always_comb begin
        redirect     = 1'b0;
        redirect_tgt = pc_inc;
        if (jump_valid_i) begin
            redirect     = 1'b1;
            redirect_tgt = jump_target_i;
        end else if (br_taken_i) begin
            redirect     = 1'b1;
            redirect_tgt = br_target_i;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pc_next_d = pc_inc;
        pc_we_d   = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (redirect) begin
                    pc_next_d = redirect_tgt;
                    pc_we_d   = 1'b1;
                    state_d   = ST_FLUSH;
                    cnt_d     = FLUSH_LOAD;
                end else if (md_start_i) begin
                    state_d = ST_MD_WAIT;
                end else if (!stall_in_i) begin
                    pc_we_d = 1'b1;
                end
            end
            ST_FLUSH: begin
                // md_start is dropped here: that instruction is being squashed.
                cnt_d = (cnt_q != 3'd0) ? cnt_q - 3'd1 : 3'd0;
                if (cnt_d == 3'd0) begin
                    state_d = ST_RUN;
                end
                if (redirect) begin
                    pc_next_d = redirect_tgt;
                    pc_we_d   = 1'b1;
                    state_d   = ST_FLUSH;
                    cnt_d     = FLUSH_LOAD;
                end else if (!stall_in_i) begin
                    pc_we_d = 1'b1;
                end
            end
            ST_MD_WAIT: begin
                if (md_ready_i) begin
                    pc_we_d = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 3'd0;
            end
        endcase

`ifdef PC_SEQ_EXC_VECTOR_EN
        if (exc_req_i) begin
            pc_next_d = EXC_VEC;
            pc_we_d   = 1'b1;
            state_d   = ST_FLUSH;
            cnt_d     = FLUSH_LOAD;
        end
`endif

        if (ctrl_reset_i) begin
            pc_next_d = pc_inc;
            pc_we_d   = 1'b0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (ctrl_reset_i) begin
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
            flush_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flush_q <= (cnt_d != 3'd0);
            busy_q  <= (state_d == ST_MD_WAIT);
        end
    end

`ifdef PC_SEQ_EXC_VECTOR_EN
    logic [PC_W-1:0] epc_q;

    always_ff @(posedge clock_i) begin
        if (ctrl_reset_i) begin
            epc_q <= '0;
        end else if (exc_req_i) begin
            epc_q <= pc_cur_i;
        end
    end

    assign epc_o = epc_q;
`endif

    assign pc_next_o   = pc_next_d;
    assign pc_we_o     = pc_we_d;
    assign flush_o     = flush_q;
    assign md_busy_o   = busy_q;
    assign seq_state_o = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : tb_pc_sequencer
// Brief    : Directed self-checking bench for pc_sequencer.
// Revision : 1.0 - initial release
//==============================================================================
module tb_pc_sequencer;

    logic        clock_i = 1'b0;
    logic        ctrl_reset_i;
    logic [11:0] pc_cur_i;
    logic        stall_in_i, md_start_i, md_ready_i, br_taken_i, jump_valid_i;
    logic [11:0] br_target_i, jump_target_i;
    logic [11:0] pc_next_o;
    logic        pc_we_o, flush_o, md_busy_o;
    logic [1:0]  seq_state_o;
`ifdef PC_SEQ_EXC_VECTOR_EN
    logic        exc_req_i = 1'b0;
    logic [11:0] epc_o;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    pc_sequencer #(.PC_W(12), .FLUSH_CYCLES(2)) dut (
        .clock_i      (clock_i),
        .ctrl_reset_i (ctrl_reset_i),
        .pc_cur_i     (pc_cur_i),
        .stall_in_i   (stall_in_i),
        .md_start_i   (md_start_i),
        .md_ready_i   (md_ready_i),
        .br_taken_i   (br_taken_i),
        .br_target_i  (br_target_i),
        .jump_valid_i (jump_valid_i),
        .jump_target_i(jump_target_i),
`ifdef PC_SEQ_EXC_VECTOR_EN
        .exc_req_i    (exc_req_i),
        .epc_o        (epc_o),
`endif
        .pc_next_o    (pc_next_o),
        .pc_we_o      (pc_we_o),
        .flush_o      (flush_o),
        .md_busy_o    (md_busy_o),
        .seq_state_o  (seq_state_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic tick;
        @(posedge clock_i);
        #1;
    endtask

    task automatic clear_inputs;
        stall_in_i = 0; md_start_i = 0; md_ready_i = 0;
        br_taken_i = 0; jump_valid_i = 0;
        br_target_i = '0; jump_target_i = '0;
    endtask

    task automatic test_reset;
        clear_inputs();
        ctrl_reset_i = 1; pc_cur_i = 12'h000;
        #1;
        n_checks++; if (pc_we_o !== 1'b0) $display("FAIL reset_we_comb: got %b want 0", pc_we_o); else n_pass++;
        tick();
        tick();
        n_checks++; if (pc_we_o !== 1'b0) $display("FAIL reset_we: got %b want 0", pc_we_o); else n_pass++;
        n_checks++; if (flush_o !== 1'b0) $display("FAIL reset_flush: got %b want 0", flush_o); else n_pass++;
        n_checks++; if (md_busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", md_busy_o); else n_pass++;
        n_checks++; if (seq_state_o !== 2'd0) $display("FAIL reset_state: got %0d want 0", seq_state_o); else n_pass++;
        ctrl_reset_i = 0;
        for (int i = 1; i <= 3; i++) begin
            pc_cur_i = 12'(i - 1);
            #1;
            n_checks++; if (pc_next_o !== 12'(i)) $display("FAIL freerun_next%0d: got %h want %h", i, pc_next_o, 12'(i)); else n_pass++;
            n_checks++; if (pc_we_o !== 1'b1) $display("FAIL freerun_we%0d: got %b want 1", i, pc_we_o); else n_pass++;
            tick();
            n_checks++; if (flush_o !== 1'b0) $display("FAIL freerun_flush%0d: got %b want 0", i, flush_o); else n_pass++;
        end
    endtask

    task automatic test_wrap_stall;
        clear_inputs();
        pc_cur_i = 12'hFFF;
        #1;
        n_checks++; if (pc_next_o !== 12'h000) $display("FAIL wrap_next: got %h want 000", pc_next_o); else n_pass++;
        n_checks++; if (pc_we_o !== 1'b1) $display("FAIL wrap_we: got %b want 1", pc_we_o); else n_pass++;
        tick();
        pc_cur_i = 12'h000; stall_in_i = 1;
        #1;
        n_checks++; if (pc_we_o !== 1'b0) $display("FAIL stall_we: got %b want 0", pc_we_o); else n_pass++;
        tick();
        n_checks++; if (seq_state_o !== 2'd0) $display("FAIL stall_state: got %0d want 0", seq_state_o); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_priority;
        clear_inputs();
        pc_cur_i = 12'h005;
        jump_valid_i = 1; jump_target_i = 12'h040;
        br_taken_i = 1;   br_target_i = 12'h080;
        #1;
        n_checks++; if (pc_next_o !== 12'h040) $display("FAIL prio_next: got %h want 040", pc_next_o); else n_pass++;
        n_checks++; if (pc_we_o !== 1'b1) $display("FAIL prio_we: got %b want 1", pc_we_o); else n_pass++;
        tick();
        clear_inputs(); pc_cur_i = 12'h040;
        #1;
        n_checks++; if (flush_o !== 1'b1) $display("FAIL prio_flush1: got %b want 1", flush_o); else n_pass++;
        n_checks++; if (seq_state_o !== 2'd2) $display("FAIL prio_state1: got %0d want 2", seq_state_o); else n_pass++;
        n_checks++; if (pc_next_o !== 12'h041 || pc_we_o !== 1'b1) $display("FAIL prio_inc_in_flush: got %h/%b want 041/1", pc_next_o, pc_we_o); else n_pass++;
        tick();
        pc_cur_i = 12'h041;
        n_checks++; if (flush_o !== 1'b1) $display("FAIL prio_flush2: got %b want 1", flush_o); else n_pass++;
        tick();
        pc_cur_i = 12'h042;
        n_checks++; if (flush_o !== 1'b0) $display("FAIL prio_flush3: got %b want 0", flush_o); else n_pass++;
        n_checks++; if (seq_state_o !== 2'd0) $display("FAIL prio_state3: got %0d want 0", seq_state_o); else n_pass++;
    endtask

    task automatic test_multdiv;
        clear_inputs();
        pc_cur_i = 12'h010; md_start_i = 1;
        #1;
        n_checks++; if (pc_we_o !== 1'b0) $display("FAIL md_issue_we: got %b want 0", pc_we_o); else n_pass++;
        tick();
        md_start_i = 0;
        for (int c = 1; c <= 5; c++) begin
            stall_in_i  = (c == 2) || (c == 5);
            br_taken_i  = (c == 3);
            br_target_i = 12'h300;
            md_ready_i  = (c == 5);
            #1;
            n_checks++; if (md_busy_o !== 1'b1) $display("FAIL md_busy%0d: got %b want 1", c, md_busy_o); else n_pass++;
            n_checks++; if (seq_state_o !== 2'd1) $display("FAIL md_state%0d: got %0d want 1", c, seq_state_o); else n_pass++;
            if (c < 5) begin
                n_checks++; if (pc_we_o !== 1'b0) $display("FAIL md_hold_we%0d: got %b want 0", c, pc_we_o); else n_pass++;
            end else begin
                n_checks++; if (pc_we_o !== 1'b1) $display("FAIL md_ready_we: got %b want 1", pc_we_o); else n_pass++;
                n_checks++; if (pc_next_o !== 12'h011) $display("FAIL md_ready_next: got %h want 011", pc_next_o); else n_pass++;
            end
            tick();
        end
        clear_inputs(); pc_cur_i = 12'h011;
        n_checks++; if (md_busy_o !== 1'b0) $display("FAIL md_exit_busy: got %b want 0", md_busy_o); else n_pass++;
        n_checks++; if (seq_state_o !== 2'd0) $display("FAIL md_exit_state: got %0d want 0", seq_state_o); else n_pass++;
        n_checks++; if (flush_o !== 1'b0) $display("FAIL md_branch_ignored: got %b want 0", flush_o); else n_pass++;
    endtask

    task automatic test_back_to_back;
        clear_inputs();
        pc_cur_i = 12'h020; br_taken_i = 1; br_target_i = 12'h100;
        #1;
        n_checks++; if (pc_next_o !== 12'h100) $display("FAIL b2b_br_next: got %h want 100", pc_next_o); else n_pass++;
        tick();
        clear_inputs(); pc_cur_i = 12'h100; jump_valid_i = 1; jump_target_i = 12'h200;
        #1;
        n_checks++; if (pc_next_o !== 12'h200) $display("FAIL b2b_jmp_next: got %h want 200", pc_next_o); else n_pass++;
        n_checks++; if (flush_o !== 1'b1) $display("FAIL b2b_flush1: got %b want 1", flush_o); else n_pass++;
        tick();
        clear_inputs(); pc_cur_i = 12'h200;
        #1;
        n_checks++; if (flush_o !== 1'b1) $display("FAIL b2b_flush2: got %b want 1", flush_o); else n_pass++;
        n_checks++; if (pc_next_o !== 12'h201) $display("FAIL b2b_inc: got %h want 201", pc_next_o); else n_pass++;
        tick();
        pc_cur_i = 12'h201;
        n_checks++; if (flush_o !== 1'b1) $display("FAIL b2b_flush3: got %b want 1", flush_o); else n_pass++;
        tick();
        pc_cur_i = 12'h202;
        n_checks++; if (flush_o !== 1'b0) $display("FAIL b2b_flush4: got %b want 0", flush_o); else n_pass++;
        n_checks++; if (seq_state_o !== 2'd0) $display("FAIL b2b_state: got %0d want 0", seq_state_o); else n_pass++;
    endtask

    task automatic test_reset_mid_wait;
        clear_inputs();
        pc_cur_i = 12'h050; md_start_i = 1;
        tick();
        md_start_i = 0;
        n_checks++; if (md_busy_o !== 1'b1) $display("FAIL rmw_busy_pre: got %b want 1", md_busy_o); else n_pass++;
        ctrl_reset_i = 1;
        tick();
        ctrl_reset_i = 0;
        n_checks++; if (md_busy_o !== 1'b0) $display("FAIL rmw_busy: got %b want 0", md_busy_o); else n_pass++;
        n_checks++; if (seq_state_o !== 2'd0) $display("FAIL rmw_state: got %0d want 0", seq_state_o); else n_pass++;
        n_checks++; if (flush_o !== 1'b0) $display("FAIL rmw_flush: got %b want 0", flush_o); else n_pass++;
        md_ready_i = 1;
        #1;
        n_checks++; if (pc_next_o !== 12'h051 || pc_we_o !== 1'b1) $display("FAIL rmw_ready_ignored: got %h/%b want 051/1", pc_next_o, pc_we_o); else n_pass++;
        tick();
        md_ready_i = 0;
        n_checks++; if (seq_state_o !== 2'd0 || md_busy_o !== 1'b0) $display("FAIL rmw_after: got %0d/%b want 0/0", seq_state_o, md_busy_o); else n_pass++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_wrap_stall();
        test_priority();
        test_multdiv();
        test_back_to_back();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC controller for the 12-bit PC register.
- Every cycle it decides whether the PC register is written and with what value: sequential increment, branch or jump redirect, hazard stall, or a multi-cycle hold while the multdiv unit is busy.
- Sits between decode/execute control and the PC register.
- After a redirect it drives a timed flush to the fetch/decode pipeline latches.

Parameters:
PC_W, 12, width of PC and all target buses
FLUSH_CYCLES, 2, cycles flush stays high after a redirect (legal range 1..7)
EXC_VEC, 12'hFF0, exception vector address (used only with EXC_VECTOR_EN)

Ports:
clock  in  1  system clock, rising edge
ctrl_reset  in  1  synchronous, active-high reset
pc_cur  in  PC_W  current output of the PC register
stall_in  in  1  data-hazard stall; hold PC this cycle
md_start  in  1  multdiv operation issued this cycle
md_ready  in  1  multdiv result valid (single-cycle pulse)
br_taken  in  1  conditional branch resolved taken
br_target  in  PC_W  absolute branch target
jump_valid  in  1  jump/jal/jr resolved
jump_target  in  PC_W  absolute jump target
pc_next  out  PC_W  value driven to the PC register data input
pc_we  out  1  write enable to the PC register
flush  out  1  squash fetch/decode latches
md_busy  out  1  high while in MD_WAIT
seq_state  out  2  encoded FSM state (debug)

Behaviour:
- One clock domain. Reset is synchronous and active-high: ctrl_reset is sampled on the rising clock edge.
- Reset values:
  - state = RUN (2'd0), flush counter = 0.
  - While ctrl_reset is high: pc_we = 0, flush = 0, md_busy = 0.
  - pc_next = pc_cur+1 (combinational, ignored because pc_we = 0).
- States: RUN (2'd0), MD_WAIT (2'd1), FLUSH (2'd2). Encoding 2'd3 is unused and returns to RUN.
- pc_next and pc_we are combinational from the inputs and state. flush, md_busy and seq_state are registered.
- Increment: pc_next = pc_cur + 1, modulo 2^PC_W. 12'hFFF wraps to 12'h000 with no flag.
- Priority in RUN and FLUSH, highest first: jump_valid > br_taken > md_start > stall_in > increment.
  - jump_valid: pc_next = jump_target, pc_we = 1. Next state FLUSH; counter loads FLUSH_CYCLES.
  - br_taken: same as jump, using br_target.
  - md_start (RUN only): pc_we = 0, next state MD_WAIT.
  - stall_in: pc_we = 0, state unchanged.
  - otherwise: increment, pc_we = 1.
- FLUSH:
  - flush = 1 while the counter is nonzero.
  - Counter decrements each cycle. When it reaches 0, next state is RUN.
  - The PC continues to increment normally during FLUSH.
  - A new redirect in FLUSH reloads the counter to FLUSH_CYCLES (re-entrant).
  - md_start in FLUSH is ignored: the instruction is being squashed.
- MD_WAIT:
  - md_busy = 1 and pc_we = 0.
  - jump_valid, br_taken and stall_in are ignored.
  - On md_ready: pc_we = 1, pc_next = pc_cur+1, next state RUN.
  - md_ready and stall_in in the same cycle: md_ready wins (exit and increment).
- md_ready outside MD_WAIT is ignored.
- md_start and md_ready in the same RUN cycle: enter MD_WAIT. md_ready is treated as stale.
- Redirect latency: target appears on pc_cur on the cycle after the request. flush is first high on that same cycle.
- ctrl_reset mid-operation (any state): next cycle state = RUN, flush = 0, counter = 0. Pending MD_WAIT is abandoned.

Optional Feature:
Macro PC_SEQ_EXC_VECTOR_EN.
- When defined:
  - Adds input exc_req (1) and output epc (PC_W, registered, reset 0).
  - exc_req has priority over everything, including MD_WAIT.
  - pc_next = EXC_VEC, pc_we = 1, epc <= pc_cur, then FLUSH with counter = FLUSH_CYCLES.
- When undefined: neither port exists and behaviour is exactly as above.

Test Plan:
- Reset then free-run: ctrl_reset high 2 cycles, then low with no requests → pc_we = 0 during reset; pc_next = 1, 2, 3 on successive cycles; flush = 0.
- Wrap: pc_cur = 12'hFFF, no requests → pc_next = 12'h000, pc_we = 1.
- Jump/branch priority: jump_valid = 1, jump_target = 12'h040, br_taken = 1, br_target = 12'h080 → pc_next = 12'h040; flush high for exactly 2 cycles; seq_state = 2 then 0.
- Multdiv hold: md_start at pc_cur = 12'h010; md_ready after 5 cycles, with stall_in = 1 and br_taken = 1 pulsed during the wait → pc_we = 0 and md_busy = 1 for all wait cycles; on the md_ready cycle pc_we = 1, pc_next = 12'h011; branch ignored.
- Re-entrant flush: br_taken to 12'h100, then jump_valid to 12'h200 one cycle later → counter reloads; flush high 3 consecutive cycles total; pc_next follows 12'h100, then 12'h200.
- Reset mid-wait: enter MD_WAIT, assert ctrl_reset for 1 cycle → state RUN, md_busy = 0, flush = 0; a later md_ready has no effect.
